// File: rtl/csr_trap_ctrl.sv
// rtl/csr_trap_ctrl.sv - M-mode CSR file with trap entry / MRET sequencer
module csr_trap_ctrl #(
    parameter logic [31:0] MTVEC_RESET  = 32'h0000_0000,
    parameter logic [31:0] MCAUSE_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] csr_rd_addr,
    output logic [31:0] csr_rd_data,
    input  logic [11:0] csr_wr_addr,
    input  logic [31:0] csr_wr_data,
    input  logic        wr_csr_n,
    input  logic        retire,
    input  logic        trap_req,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic        mret_req,
    output logic        busy,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_TRAP_SAVE = 2'd1,
        S_TRAP_JUMP = 2'd2,
        S_MRET_JUMP = 2'd3
    } state_e;

    state_e      state_q;
    logic [31:0] trap_cause_q;
    logic [31:0] trap_pc_q;
    logic        redirect_q;
    logic [31:0] redirect_pc_q;

    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    logic        idle;
    logic        wr_accept;
    logic        wr_writable;
    logic [31:0] csr_value;

    // Value a write to addr would read back as once stored
    function automatic logic [31:0] legalize(input logic [11:0] addr, input logic [31:0] data);
        case (addr)
            CSR_MSTATUS:            legalize = {19'd0, 2'b11, 3'd0, data[7], 3'd0, data[3], 3'd0};
            CSR_MTVEC, CSR_MEPC:    legalize = {data[31:2], 2'b00};
            CSR_MSCRATCH, CSR_MCAUSE,
            CSR_MCYCLE, CSR_MCYCLEH,
            CSR_MINSTRET, CSR_MINSTRETH: legalize = data;
            default:                legalize = 32'd0;
        endcase
    endfunction

    assign idle = (state_q == S_IDLE);
    // Trap beats MRET beats a pipeline write; nothing is accepted while busy
    assign wr_accept = idle && !wr_csr_n && !trap_req && !mret_req;

    // Addresses that actually store a pipeline write (aliases and holes do not)
    always_comb begin
        case (csr_wr_addr)
            CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: wr_writable = 1'b1;
            default: wr_writable = 1'b0;
        endcase
    end

    // Legalized view of the stored CSR selected by the read address
    always_comb begin
        case (csr_rd_addr)
            CSR_MSTATUS:                 csr_value = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
            CSR_MTVEC:                   csr_value = mtvec_q;
            CSR_MSCRATCH:                csr_value = mscratch_q;
            CSR_MEPC:                    csr_value = mepc_q;
            CSR_MCAUSE:                  csr_value = mcause_q;
            CSR_MCYCLE, CSR_CYCLE:       csr_value = mcycle_q[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:     csr_value = mcycle_q[63:32];
            CSR_MINSTRET, CSR_INSTRET:   csr_value = minstret_q[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: csr_value = minstret_q[63:32];
            default:                     csr_value = 32'd0;
        endcase
    end

    // Forward an accepted same-address write so ID sees the value WB is storing
    assign csr_rd_data = (wr_accept && wr_writable && (csr_wr_addr == csr_rd_addr))
                       ? legalize(csr_wr_addr, csr_wr_data) : csr_value;

    // CSR next-state: free-running counters, pipeline writes, trap/MRET side effects
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mscratch_d = mscratch_q;
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, retire};

        if (wr_accept) begin
            case (csr_wr_addr)
                CSR_MSTATUS: begin
                    mie_d  = csr_wr_data[3];
                    mpie_d = csr_wr_data[7];
                end
                CSR_MTVEC:     mtvec_d    = {csr_wr_data[31:2], 2'b00};
                CSR_MSCRATCH:  mscratch_d = csr_wr_data;
                CSR_MEPC:      mepc_d     = {csr_wr_data[31:2], 2'b00};
                CSR_MCAUSE:    mcause_d   = csr_wr_data;
                CSR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], csr_wr_data};
                CSR_MCYCLEH:   mcycle_d   = {csr_wr_data, mcycle_q[31:0]};
                CSR_MINSTRET:  minstret_d = {minstret_q[63:32], csr_wr_data};
                CSR_MINSTRETH: minstret_d = {csr_wr_data, minstret_q[31:0]};
                default: ;
            endcase
        end

        if (state_q == S_TRAP_SAVE) begin
            mepc_d   = {trap_pc_q[31:2], 2'b00};
            mcause_d = trap_cause_q;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (state_q == S_MRET_JUMP) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
    end

    // CSR storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
            mepc_q     <= 32'd0;
            mcause_q   <= MCAUSE_RESET;
            mscratch_q <= 32'd0;
            mcycle_q   <= 64'd0;
            minstret_q <= 64'd0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mscratch_q <= mscratch_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    // Trap/MRET sequencer; redirect is raised on entry to a JUMP state so it spans that cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            trap_cause_q  <= 32'd0;
            trap_pc_q     <= 32'd0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
        end else begin
            redirect_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (trap_req) begin
                        state_q      <= S_TRAP_SAVE;
                        trap_cause_q <= trap_cause;
                        trap_pc_q    <= trap_pc;
                    end else if (mret_req) begin
                        state_q       <= S_MRET_JUMP;
                        redirect_q    <= 1'b1;
                        redirect_pc_q <= mepc_q;
                    end
                end
                S_TRAP_SAVE: begin
                    state_q       <= S_TRAP_JUMP;
                    redirect_q    <= 1'b1;
                    redirect_pc_q <= mtvec_q;
                end
                S_TRAP_JUMP: state_q <= S_IDLE;
                S_MRET_JUMP: state_q <= S_IDLE;
                default:     state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = !idle;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb/tb_csr_trap_ctrl.sv - self-checking bench for csr_trap_ctrl
`timescale 1ns/1ps
module tb_csr_trap_ctrl;

    localparam logic [31:0] P_MTVEC  = 32'h0000_0200;
    localparam logic [31:0] P_MCAUSE = 32'h0000_000B;

    logic        clk;
    logic        rst_n;
    logic [11:0] csr_rd_addr;
    logic [31:0] csr_rd_data;
    logic [11:0] csr_wr_addr;
    logic [31:0] csr_wr_data;
    logic        wr_csr_n;
    logic        retire;
    logic        trap_req;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic        mret_req;
    logic        busy;
    logic        redirect;
    logic [31:0] redirect_pc;

    int n_cmp  = 0;
    int n_fail = 0;

    csr_trap_ctrl #(.MTVEC_RESET(P_MTVEC), .MCAUSE_RESET(P_MCAUSE)) dut (
        .clk(clk), .rst_n(rst_n),
        .csr_rd_addr(csr_rd_addr), .csr_rd_data(csr_rd_data),
        .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data), .wr_csr_n(wr_csr_n),
        .retire(retire), .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .mret_req(mret_req), .busy(busy), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural state, 64-bit counters, and a busy countdown
    bit          m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_mscratch;
    logic [63:0] m_cyc, m_ins;
    int          m_left;     // busy cycles still to go
    bit          m_is_trap;  // current busy period belongs to a trap (else MRET)
    logic [31:0] m_tcause, m_tpc;
    bit          m_redir;
    logic [31:0] m_rpc;

    function automatic void model_reset();
        m_mie = 0; m_mpie = 0;
        m_mtvec = P_MTVEC & ~32'h3; m_mepc = 0; m_mcause = P_MCAUSE; m_mscratch = 0;
        m_cyc = 0; m_ins = 0;
        m_left = 0; m_is_trap = 0; m_tcause = 0; m_tpc = 0;
        m_redir = 0; m_rpc = 0;
    endfunction

    function automatic bit m_writable(input logic [11:0] a);
        return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                         12'hB00, 12'hB80, 12'hB02, 12'hB82};
    endfunction

    function automatic logic [31:0] m_legal(input logic [11:0] a, input logic [31:0] d);
        if (a == 12'h300) return 32'h1800 | (d & 32'h88);
        if (a == 12'h305 || a == 12'h341) return d & ~32'h3;
        if (m_writable(a)) return d;
        return 32'h0;
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hB00, 12'hC00: return m_cyc[31:0];
            12'hB80, 12'hC80: return m_cyc[63:32];
            12'hB02, 12'hC02: return m_ins[31:0];
            12'hB82, 12'hC82: return m_ins[63:32];
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_wacc();
        return (m_left == 0) && !wr_csr_n && !trap_req && !mret_req;
    endfunction

    function automatic logic [31:0] m_expect_rd();
        if (m_wacc() && csr_wr_addr == csr_rd_addr && m_writable(csr_wr_addr))
            return m_legal(csr_wr_addr, csr_wr_data);
        return m_read(csr_rd_addr);
    endfunction

    // Advance the model by one clock using the inputs presented this cycle
    function automatic void model_edge();
        logic [63:0] cyc_n, ins_n;
        bit idle;
        idle  = (m_left == 0);
        cyc_n = m_cyc + 64'd1;
        ins_n = m_ins + (retire ? 64'd1 : 64'd0);
        m_redir = 0;
        if (m_wacc()) begin
            case (csr_wr_addr)
                12'h300: begin m_mie = csr_wr_data[3]; m_mpie = csr_wr_data[7]; end
                12'h305: m_mtvec = csr_wr_data & ~32'h3;
                12'h340: m_mscratch = csr_wr_data;
                12'h341: m_mepc = csr_wr_data & ~32'h3;
                12'h342: m_mcause = csr_wr_data;
                12'hB00: cyc_n = {m_cyc[63:32], csr_wr_data};
                12'hB80: cyc_n = {csr_wr_data, m_cyc[31:0]};
                12'hB02: ins_n = {m_ins[63:32], csr_wr_data};
                12'hB82: ins_n = {csr_wr_data, m_ins[31:0]};
                default: ;
            endcase
        end
        if (!idle) begin
            if (m_is_trap && m_left == 2) begin
                m_mepc = m_tpc & ~32'h3;
                m_mcause = m_tcause;
                m_mpie = m_mie;
                m_mie = 0;
                m_redir = 1;
                m_rpc = m_mtvec;
            end else if (!m_is_trap) begin
                m_mie = m_mpie;
                m_mpie = 1;
            end
            m_left = m_left - 1;
        end else if (trap_req) begin
            m_is_trap = 1; m_left = 2; m_tcause = trap_cause; m_tpc = trap_pc;
        end else if (mret_req) begin
            m_is_trap = 0; m_left = 1; m_redir = 1; m_rpc = m_mepc;
        end
        m_cyc = cyc_n;
        m_ins = ins_n;
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        csr_rd_addr = 12'h000; csr_wr_addr = 12'h000; csr_wr_data = 32'h0;
        wr_csr_n = 1'b1; retire = 1'b0; trap_req = 1'b0; trap_cause = 32'h0;
        trap_pc = 32'h0; mret_req = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        quiet_inputs();
        #2;
        model_reset();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        do_reset();
        csr_rd_addr = 12'h300; #1;
        n_cmp++; if (csr_rd_data !== 32'h0000_1800) begin n_fail++; $display("FAIL reset_mstatus: got %h want %h", csr_rd_data, 32'h0000_1800); end
        csr_rd_addr = 12'h305; #1;
        n_cmp++; if (csr_rd_data !== P_MTVEC) begin n_fail++; $display("FAIL reset_mtvec: got %h want %h", csr_rd_data, P_MTVEC); end
        csr_rd_addr = 12'h342; #1;
        n_cmp++; if (csr_rd_data !== P_MCAUSE) begin n_fail++; $display("FAIL reset_mcause: got %h want %h", csr_rd_data, P_MCAUSE); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL reset_redirect: got %b want 0", redirect); end
        n_cmp++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_redirect_pc: got %h want 0", redirect_pc); end
    endtask

    task automatic test_trap_entry();
        csr_wr_addr = 12'h305; csr_wr_data = 32'h0000_0103; wr_csr_n = 1'b0;
        tick();
        wr_csr_n = 1'b1;
        csr_rd_addr = 12'h305; #1;
        n_cmp++; if (csr_rd_data !== 32'h100) begin n_fail++; $display("FAIL mtvec_legal: got %h want %h", csr_rd_data, 32'h100); end
        trap_req = 1'b1; trap_cause = 32'd2; trap_pc = 32'h0000_0046; #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL trap_req_cycle_busy: got %b want 0", busy); end
        tick();
        trap_req = 1'b0; #1;
        n_cmp++; if (busy !== 1'b1 || redirect !== 1'b0) begin n_fail++; $display("FAIL trap_save: busy %b redirect %b want 1 0", busy, redirect); end
        tick();
        n_cmp++; if (busy !== 1'b1 || redirect !== 1'b1) begin n_fail++; $display("FAIL trap_jump: busy %b redirect %b want 1 1", busy, redirect); end
        n_cmp++; if (redirect_pc !== 32'h100) begin n_fail++; $display("FAIL trap_redirect_pc: got %h want %h", redirect_pc, 32'h100); end
        tick();
        n_cmp++; if (busy !== 1'b0 || redirect !== 1'b0) begin n_fail++; $display("FAIL trap_done: busy %b redirect %b want 0 0", busy, redirect); end
        n_cmp++; if (redirect_pc !== 32'h100) begin n_fail++; $display("FAIL redirect_pc_hold: got %h want %h", redirect_pc, 32'h100); end
        csr_rd_addr = 12'h341; #1;
        n_cmp++; if (csr_rd_data !== 32'h44) begin n_fail++; $display("FAIL trap_mepc: got %h want %h", csr_rd_data, 32'h44); end
        csr_rd_addr = 12'h342; #1;
        n_cmp++; if (csr_rd_data !== 32'h2) begin n_fail++; $display("FAIL trap_mcause: got %h want %h", csr_rd_data, 32'h2); end
    endtask

    task automatic test_mret();
        csr_wr_addr = 12'h300; csr_wr_data = 32'h0000_0008; wr_csr_n = 1'b0;
        tick();
        wr_csr_n = 1'b1;
        csr_rd_addr = 12'h300; #1;
        n_cmp++; if (csr_rd_data !== 32'h1808) begin n_fail++; $display("FAIL mie_set: got %h want %h", csr_rd_data, 32'h1808); end
        trap_req = 1'b1; trap_cause = 32'd5; trap_pc = 32'h0000_1002;
        tick();
        trap_req = 1'b0;
        tick(); tick();
        #1;
        n_cmp++; if (csr_rd_data !== 32'h1880) begin n_fail++; $display("FAIL trap_mstatus: got %h want %h", csr_rd_data, 32'h1880); end
        mret_req = 1'b1; #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mret_req_cycle_busy: got %b want 0", busy); end
        tick();
        mret_req = 1'b0; #1;
        n_cmp++; if (busy !== 1'b1 || redirect !== 1'b1) begin n_fail++; $display("FAIL mret_jump: busy %b redirect %b want 1 1", busy, redirect); end
        n_cmp++; if (redirect_pc !== 32'h1000) begin n_fail++; $display("FAIL mret_redirect_pc: got %h want %h", redirect_pc, 32'h1000); end
        tick();
        n_cmp++; if (busy !== 1'b0 || redirect !== 1'b0) begin n_fail++; $display("FAIL mret_done: busy %b redirect %b want 0 0", busy, redirect); end
        n_cmp++; if (csr_rd_data !== 32'h1888) begin n_fail++; $display("FAIL mret_mstatus: got %h want %h", csr_rd_data, 32'h1888); end
    endtask

    task automatic test_trap_vs_write();
        logic [31:0] old_scratch;
        old_scratch = m_mscratch;
        trap_req = 1'b1; trap_cause = 32'd7; trap_pc = 32'h0000_2000;
        wr_csr_n = 1'b0; csr_wr_addr = 12'h340; csr_wr_data = 32'h0000_DEAD;
        csr_rd_addr = 12'h340; #1;
        n_cmp++; if (csr_rd_data !== old_scratch) begin n_fail++; $display("FAIL no_forward_on_trap: got %h want %h", csr_rd_data, old_scratch); end
        tick();
        wr_csr_n = 1'b1;
        tick();
        n_cmp++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL held_trap_redirect: got %b want 1", redirect); end
        trap_req = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL held_trap_not_reaccepted: busy %b want 0", busy); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL held_trap_idle: busy %b want 0", busy); end
        n_cmp++; if (csr_rd_data !== old_scratch) begin n_fail++; $display("FAIL mscratch_unchanged: got %h want %h", csr_rd_data, old_scratch); end
    endtask

    task automatic test_counters();
        wr_csr_n = 1'b0; csr_wr_addr = 12'hB80; csr_wr_data = 32'h0;
        tick();
        csr_wr_addr = 12'hB00; csr_wr_data = 32'hFFFF_FFFF;
        tick();
        wr_csr_n = 1'b1;
        csr_rd_addr = 12'hB00; #1;
        n_cmp++; if (csr_rd_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mcycle_written: got %h want %h", csr_rd_data, 32'hFFFF_FFFF); end
        tick();
        n_cmp++; if (csr_rd_data !== 32'h0) begin n_fail++; $display("FAIL mcycle_wrap: got %h want 0", csr_rd_data); end
        csr_rd_addr = 12'hB80; #1;
        n_cmp++; if (csr_rd_data !== 32'h1) begin n_fail++; $display("FAIL mcycleh_carry: got %h want 1", csr_rd_data); end
        csr_rd_addr = 12'hC80; #1;
        n_cmp++; if (csr_rd_data !== 32'h1) begin n_fail++; $display("FAIL cycleh_alias: got %h want 1", csr_rd_data); end
        wr_csr_n = 1'b0; csr_wr_addr = 12'hB02; csr_wr_data = 32'h0;
        tick();
        csr_wr_addr = 12'hB82;
        tick();
        wr_csr_n = 1'b1;
        retire = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        retire = 1'b0;
        csr_rd_addr = 12'hB02; #1;
        n_cmp++; if (csr_rd_data !== 32'd5) begin n_fail++; $display("FAIL minstret_count: got %h want 5", csr_rd_data); end
        csr_rd_addr = 12'hC02; #1;
        n_cmp++; if (csr_rd_data !== 32'd5) begin n_fail++; $display("FAIL instret_alias: got %h want 5", csr_rd_data); end
        wr_csr_n = 1'b0; csr_wr_addr = 12'hC02; csr_wr_data = 32'h55;
        tick();
        wr_csr_n = 1'b1; #1;
        n_cmp++; if (csr_rd_data !== 32'd5) begin n_fail++; $display("FAIL alias_write_ignored: got %h want 5", csr_rd_data); end
    endtask

    task automatic test_read_port();
        csr_rd_addr = 12'h340; csr_wr_addr = 12'h340; csr_wr_data = 32'h1234; wr_csr_n = 1'b0; #1;
        n_cmp++; if (csr_rd_data !== 32'h1234) begin n_fail++; $display("FAIL forward_mscratch: got %h want %h", csr_rd_data, 32'h1234); end
        csr_rd_addr = 12'h300; csr_wr_addr = 12'h300; csr_wr_data = 32'hFFFF_FFFF; #1;
        n_cmp++; if (csr_rd_data !== 32'h1888) begin n_fail++; $display("FAIL forward_mstatus_legal: got %h want %h", csr_rd_data, 32'h1888); end
        wr_csr_n = 1'b1;
        csr_rd_addr = 12'h7C0; #1;
        n_cmp++; if (csr_rd_data !== 32'h0) begin n_fail++; $display("FAIL unimpl_read: got %h want 0", csr_rd_data); end
        tick();
    endtask

    function automatic logic [11:0] pick_addr(input int k);
        case (k)
            0: return 12'h300;  1: return 12'h305;  2: return 12'h340;  3: return 12'h341;
            4: return 12'h342;  5: return 12'hB00;  6: return 12'hB80;  7: return 12'hB02;
            8: return 12'hB82;  9: return 12'hC00; 10: return 12'hC80; 11: return 12'hC02;
            12: return 12'hC82; 13: return 12'h7C0; default: return 12'(($urandom));
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] exp_rd;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0; #1;
                n_cmp++; if (busy !== 1'b0 || redirect !== 1'b0) begin n_fail++; $display("FAIL rand_async_reset cyc %0d: busy %b redirect %b want 0 0", cyc, busy, redirect); end
                model_reset();
                rst_n = 1'b1;
            end
            csr_rd_addr = pick_addr($urandom_range(0, 15));
            csr_wr_addr = ($urandom_range(0, 3) == 0) ? csr_rd_addr : pick_addr($urandom_range(0, 15));
            csr_wr_data = $urandom;
            wr_csr_n    = ($urandom_range(0, 1) == 0);
            retire      = ($urandom_range(0, 1) == 0);
            trap_req    = ($urandom_range(0, 9) == 0);
            mret_req    = ($urandom_range(0, 9) == 0);
            trap_cause  = $urandom;
            trap_pc     = $urandom;
            #1;
            exp_rd = m_expect_rd();
            n_cmp++; if (csr_rd_data !== exp_rd) begin n_fail++; $display("FAIL rand_rd cyc %0d addr %h: got %h want %h", cyc, csr_rd_addr, csr_rd_data, exp_rd); end
            n_cmp++; if (busy !== (m_left != 0)) begin n_fail++; $display("FAIL rand_busy cyc %0d: got %b want %b", cyc, busy, (m_left != 0)); end
            n_cmp++; if (redirect !== m_redir) begin n_fail++; $display("FAIL rand_redirect cyc %0d: got %b want %b", cyc, redirect, m_redir); end
            n_cmp++; if (redirect_pc !== m_rpc) begin n_fail++; $display("FAIL rand_redirect_pc cyc %0d: got %h want %h", cyc, redirect_pc, m_rpc); end
            tick();
        end
        quiet_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        quiet_inputs();
        model_reset();
        test_reset();
        test_trap_entry();
        test_mret();
        test_trap_vs_write();
        test_counters();
        test_read_port();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
